bridge_commutation_sequencer: RTL

//  Sequences the four-leg power bridge gate outputs (o_top[4:1]/o_bot[4:1]) between bridge modes.
//  Any change of conducting pair inserts a dead-time interval with all gates LOW.
//  An optional minimum on-time holds off further mode changes.
//  A fault input kills the bridge immediately.

---
 rtl/bridge_pkg.sv | 35 +++
 rtl/bridge_timer.sv | 38 +++
 rtl/bridge_commutation_sequencer.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/bridge_pkg.sv
// Shared types and gate-pattern lookup for the four-leg bridge commutation sequencer.
// The optional minimum on-time hold-off is enabled by defining BRIDGE_MIN_ON_EN.
package bridge_pkg;

    typedef enum logic [2:0] {
        PAUSE = 3'd0,
        PLUS  = 3'd1,
        MINUS = 3'd2,
        BAL_P = 3'd3,
        BAL_N = 3'd4
    } mode_t;

    typedef enum logic [1:0] {
        S_OFF   = 2'd0,
        S_DEAD  = 2'd1,
        S_ON    = 2'd2,
        S_FAULT = 2'd3
    } state_t;

    localparam logic [2:0] MODE_LAST = 3'd4;

    // Returns {top[4:1], bot[4:1]}; codes outside the enum yield all gates LOW.
    function automatic logic [7:0] mode_to_gates(input mode_t m);
        logic [7:0] g;
        case (m)
            PLUS:    g = 8'b0001_0010;
            MINUS:   g = 8'b0010_0001;
            BAL_P:   g = 8'b0100_1000;
            BAL_N:   g = 8'b1000_0100;
            default: g = 8'b0000_0000;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/bridge_timer.sv
// Loadable down-counter shared by the dead-time and minimum on-time intervals.
// Load wins over decrement; decrement saturates at zero.
module bridge_timer #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             dec_i,
    output logic [CNT_W-1:0] value_o,
    output logic             zero_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign value_o = cnt_q;
    assign zero_o  = (cnt_q == '0);

endmodule

// File: rtl/bridge_commutation_sequencer.sv
// Sequences bridge gate pairs with enforced dead time, fault kill and (with
// BRIDGE_MIN_ON_EN defined) a minimum on-time hold-off before the next mode change.
module bridge_commutation_sequencer
    import bridge_pkg::*;
#(
    parameter int DEADTIME_CYC = 50,
    parameter int MIN_ON_CYC   = 500,
    parameter int CNT_W        = 16
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [2:0] req_mode,
    input  logic       fault,
    output logic [3:0] o_top,
    output logic [3:0] o_bot,
    output logic [2:0] cur_mode,
    output logic       busy,
    output logic       err_illegal,
    output state_t     dbg_state
);

    if (DEADTIME_CYC < 1) begin : g_bad_deadtime
        $error("DEADTIME_CYC must be >= 1");
    end
    if (MIN_ON_CYC < 1) begin : g_bad_min_on
        $error("MIN_ON_CYC must be >= 1");
    end
    if ((longint'(DEADTIME_CYC) > ((64'd1 << CNT_W) - 64'd1)) ||
        (longint'(MIN_ON_CYC)   > ((64'd1 << CNT_W) - 64'd1))) begin : g_bad_width
        $error("DEADTIME_CYC / MIN_ON_CYC do not fit in CNT_W bits");
    end

    localparam logic [CNT_W-1:0] DEAD_LOAD  = CNT_W'(DEADTIME_CYC);
    localparam logic [CNT_W-1:0] MINON_LOAD = CNT_W'(MIN_ON_CYC);

    state_t     state_q, state_d;
    mode_t      target_q, target_d;
    mode_t      cur_mode_q, cur_mode_d;
    logic [7:0] gates_q, gates_d;
    logic       err_q, err_d;

    logic             tmr_load, tmr_dec, tmr_zero;
    logic [CNT_W-1:0] tmr_load_val, tmr_value;
    logic             hold_ok, dead_done, accept, req_legal;
    mode_t            req_eff;

    bridge_timer #(.CNT_W(CNT_W)) u_timer (
        .clk        (clk),
        .rstn       (rstn),
        .load_i     (tmr_load),
        .load_val_i (tmr_load_val),
        .dec_i      (tmr_dec),
        .value_o    (tmr_value),
        .zero_o     (tmr_zero)
    );

`ifdef BRIDGE_MIN_ON_EN
    assign hold_ok = tmr_zero;
`else
    assign hold_ok = 1'b1;
`endif

    // Handshake: a request is taken on a clk edge where req_valid && req_ready;
    // req_ready never depends on req_valid and is forced low by fault or reset.
    assign req_legal = (req_mode <= MODE_LAST);
    assign req_eff   = req_legal ? mode_t'(req_mode) : PAUSE;
    assign accept    = req_valid && req_ready;
    assign dead_done = (tmr_value == CNT_W'(1)) || tmr_zero;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= S_OFF;
            target_q   <= PAUSE;
            cur_mode_q <= PAUSE;
            gates_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            target_q   <= target_d;
            cur_mode_q <= cur_mode_d;
            gates_q    <= gates_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        target_d     = target_q;
        tmr_load     = 1'b0;
        tmr_load_val = DEAD_LOAD;
        tmr_dec      = 1'b0;
        if (fault) begin
            state_d  = S_FAULT;
            target_d = PAUSE;
        end else begin
            case (state_q)
                S_OFF, S_ON: begin
                    if (accept && (req_eff != cur_mode_q)) begin
                        state_d  = S_DEAD;
                        target_d = req_eff;
                        tmr_load = 1'b1;
                    end else begin
                        tmr_dec = (state_q == S_ON);
                    end
                end
                S_DEAD: begin
                    tmr_dec = 1'b1;
                    if (dead_done) begin
                        if (target_q == PAUSE) begin
                            state_d = S_OFF;
                        end else begin
                            state_d = S_ON;
`ifdef BRIDGE_MIN_ON_EN
                            tmr_load     = 1'b1;
                            tmr_load_val = MINON_LOAD;
`endif
                        end
                    end
                end
                S_FAULT: begin
                    state_d  = S_DEAD;
                    target_d = PAUSE;
                    tmr_load = 1'b1;
                end
                default: begin
                    state_d  = S_FAULT;
                    target_d = PAUSE;
                end
            endcase
        end
    end

    // Gates are registered from the next state so only a settled S_ON pair is ever driven.
    always_comb begin
        req_ready  = rstn && !fault &&
                     ((state_q == S_OFF) || ((state_q == S_ON) && hold_ok));
        gates_d    = (state_d == S_ON) ? mode_to_gates(target_d) : 8'h00;
        cur_mode_d = (state_d == S_ON) ? target_d : PAUSE;
        err_d      = accept && !req_legal;
    end

    assign o_top       = gates_q[7:4];
    assign o_bot       = gates_q[3:0];
    assign cur_mode    = cur_mode_q;
    assign busy        = (state_q == S_DEAD) || (state_q == S_FAULT);
    assign err_illegal = err_q;
    assign dbg_state   = state_q;

endmodule
